// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns over a 128-bit state.
// One shared column datapath processes the four columns serially, one per
// clock. Valid/ready handshakes sit on both sides, with a three-state control
// FSM (IDLE -> BUSY -> DONE).
//
// Layout: column c occupies bits [127-32c : 96-32c]. Byte 0 of a column is
// its most significant byte.
//
// Latency: a state accepted at edge E0 has its columns written at E1..E4.
// out_valid is high in the cycle after E4.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Column being transformed while BUSY; wraps back to 0 after column 3.
  logic [1:0]   col_cnt;
  // Copy of state_in taken at acceptance, so later input changes are harmless.
  logic [127:0] data_q;
  // Columns 0..2 of the result in flight. Column 3 is produced on the final
  // BUSY edge and goes straight into the output register with them.
  logic [95:0]  result_q;
  // Last completed result. It only changes when a new state completes, so
  // state_out never shows a partial result.
  logic [127:0] out_q;

  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // GF(2^8) multiply by 2, reducing by the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column {a0,a1,a2,a3} (a0 in the MSB byte).
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    // 3a = xtime(a) ^ a, so each 3a term becomes x ^ a.
    b0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    b3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    return {b0, b1, b2, b3};
  endfunction

  // Select the captured column addressed by col_cnt and run the shared datapath.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    col_in = data_q[127:96];
    unique case (col_cnt)
      2'd0: col_in = data_q[127:96];
      2'd1: col_in = data_q[95:64];
      2'd2: col_in = data_q[63:32];
      2'd3: col_in = data_q[31:0];
      default: col_in = data_q[127:96];
    endcase
    col_out = mix_column(col_in);
  end

  // State register. Reset is synchronous and wins over everything else.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples pre-edge values and simulation ordering cannot change results.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. in_valid only matters in IDLE, out_ready only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (col_cnt == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are decoded purely from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      BUSY:    ;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: capture on acceptance, then write one column per BUSY edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are plain flops, not a memory, so all of them are cleared
      // on reset. state_out then reads zero right after an abort.
      col_cnt  <= 2'd0;
      data_q   <= 128'h0;
      result_q <= 96'h0;
      out_q    <= 128'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= state_in;
            col_cnt <= 2'd0;
          end
        end
        BUSY: begin
          col_cnt <= col_cnt + 2'd1;
          unique case (col_cnt)
            2'd0: result_q[95:64] <= col_out;
            2'd1: result_q[63:32] <= col_out;
            2'd2: result_q[31:0]  <= col_out;
            2'd3: out_q           <= {result_q, col_out};
            default: ;
          endcase
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq.
// It covers the FIPS-197 and second column vectors, exact latency, output
// backpressure with in_valid noise, reset mid-operation, and a 1000-vector
// round trip through a behavioural inverse MixColumns with random out_ready.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int checks;
  int failures;

  localparam logic [127:0] VEC1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VEC1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle just after it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural GF(2^8) multiply (shift-and-add) for the inverse model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_col(s[127:96]), inv_col(s[95:64]), inv_col(s[63:32]), inv_col(s[31:0])};
  endfunction

  // Accept vec at E0 and scramble state_in afterwards.
  // out_valid must stay low through E3, rise after E4, and carry exp.
  task automatic run_vector(input string tag, input logic [127:0] vec,
                            input logic [127:0] exp);
    check({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1'b1));
    state_in = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    state_in = ~vec;
    check({tag, "_in_ready_busy"}, 128'(in_ready), 128'(1'b0));
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("%s_out_valid_pre_E%0d", tag, i), 128'(out_valid), 128'(1'b0));
      step();
    end
    check({tag, "_out_valid_after_E4"}, 128'(out_valid), 128'(1'b1));
    check({tag, "_state_out"}, state_out, exp);
  endtask

  // Complete the output handshake; the result must persist into IDLE.
  task automatic handshake(input string tag, input logic [127:0] exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, "_hs_in_ready"}, 128'(in_ready), 128'(1'b1));
    check({tag, "_hs_state_out_held"}, state_out, exp);
  endtask

  initial begin
    logic [127:0] vec;
    logic [127:0] res;
    logic         got;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = 128'h0;
    res       = 128'h0;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", 128'(in_ready), 128'(1'b1));
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_state_out", state_out, 128'h0);

    // Idle with in_valid low stays idle.
    step();
    check("idle_hold_in_ready", 128'(in_ready), 128'(1'b1));

    // FIPS-197 column vector, then the second vector.
    run_vector("vec1", VEC1_IN, VEC1_OUT);
    handshake("vec1", VEC1_OUT);
    run_vector("vec2", VEC2_IN, VEC2_OUT);
    handshake("vec2", VEC2_OUT);

    // Backpressure: hold out_ready low for 10 cycles while in_valid toggles
    // with new data. Nothing may change.
    run_vector("bp", VEC1_IN, VEC1_OUT);
    state_in = VEC2_IN;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      step();
      check($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'(1'b1));
      check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'(1'b0));
      check($sformatf("bp_state_out_%0d", i), state_out, VEC1_OUT);
    end
    // in_valid high on the handshake edge must not be taken in DONE.
    in_valid = 1'b1;
    handshake("bp", VEC1_OUT);
    in_valid = 1'b0;
    run_vector("bp_next", VEC2_IN, VEC2_OUT);
    handshake("bp_next", VEC2_OUT);

    // Reset two cycles after acceptance, with in_valid also high: the
    // operation aborts, reset wins, and everything reads as after reset.
    state_in = VEC1_IN;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    check("midrst_state_out", state_out, 128'h0);
    step();
    step();
    check("midrst_no_late_valid", 128'(out_valid), 128'(1'b0));
    run_vector("after_rst", VEC1_IN, VEC1_OUT);
    handshake("after_rst", VEC1_OUT);

    // Round trip through the inverse model with random out_ready.
    for (int n = 0; n < 1000; n++) begin
      vec      = {$urandom, $urandom, $urandom, $urandom};
      state_in = vec;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      got      = 1'b0;
      for (int c = 0; c < 64 && !got; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          res = state_out;
          got = 1'b1;
        end
        step();
      end
      out_ready = 1'b0;
      check($sformatf("rt_done_%0d", n), 128'(got), 128'(1'b1));
      check($sformatf("rt_recover_%0d", n), inv_mix(res), vec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  state_in holds a valid 128-bit AES state.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 state_in  input  128  state to transform; column c = bits [127-32c : 96-32c], byte 0 of a column = its MSB byte.
REQ-007 out_valid  output  1  state_out holds a completed result.
REQ-008 out_ready  input  1  consumer accepts state_out this cycle.
REQ-009 state_out  output  128  forward MixColumns result; same column/byte layout as state_in.

Function
REQ-010 The block SHALL compute forward AES MixColumns, the counterpart of the existing inverse MixColumns. Per column (a0..a3) -> (b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
REQ-011 GF(2^8) multiplication rules:
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1B : 8'h00)
  - 3x = xtime(x) ^ x
  - all results 8 bits, no carries.
REQ-012 Exactly one column-datapath instance SHALL be built; the four columns SHALL be processed serially, one per cycle.
REQ-013 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 IDLE behaviour:
  - in_ready = 1.
  - in_valid=1 at an edge: capture state_in into an internal register, clear column counter to 0, go to BUSY.
  - in_valid=0: stay in IDLE.
REQ-015 BUSY behaviour, each edge:
  - write the transform of column col_cnt into the result register at that column's position.
  - increment col_cnt (2 bits).
  - after column 3 is written: go to DONE; col_cnt wraps to 0.
REQ-016 DONE behaviour:
  - out_valid = 1 and state_out stable.
  - out_ready=1 at an edge: go to IDLE.
  - out_ready=0: hold indefinitely, all outputs unchanged.
REQ-017 Latency: acceptance edge E0, columns written at E1..E4, out_valid high in the cycle after E4, i.e. exactly 4 cycles after acceptance.
REQ-018 in_ready SHALL be 0 in BUSY and DONE. in_valid in those states SHALL be ignored and SHALL NOT disturb the captured state.
REQ-019 After the out_ready handshake in DONE, the next state SHALL be accepted no earlier than the following cycle in IDLE. Minimum throughput is one state per 6 cycles.
REQ-020 state_in changing after acceptance SHALL NOT affect the result.
REQ-021 out_valid SHALL be 0 in IDLE and BUSY. state_out SHALL keep the last completed result until the next completion overwrites it.

Reset
REQ-022 When rst=1 at an edge:
  - FSM goes to IDLE.
  - col_cnt = 0.
  - internal state and result registers = 128'h0.
  - in_ready = 1, out_valid = 0, state_out = 128'h0 from the next cycle.
REQ-023 Reset in BUSY or DONE SHALL abort the operation; no partial result SHALL ever be flagged valid.
REQ-024 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-025 FIPS-197 columns:
  - stimulus: state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6, in_valid pulse.
  - response: state_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 4 cycles after acceptance.
REQ-026 Second vector:
  - stimulus: state_in = 128'hd4d4d4d5_2d26314c_00000000_ffffffff.
  - response: state_out = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff.
REQ-027 Backpressure:
  - stimulus: out_ready held 0 for 10 cycles after completion, in_valid toggled with new data meanwhile.
  - response: state_out and out_valid stay constant, in_ready stays 0, second state not captured until IDLE.
REQ-028 Reset mid-operation:
  - stimulus: rst asserted for one cycle 2 cycles after acceptance.
  - response: next cycle out_valid=0, in_ready=1, state_out=0; a new vector then completes correctly.
REQ-029 Round trip:
  - stimulus: random states driven through this block and then the existing inverse MixColumns block.
  - response: the original state is recovered for 1000 vectors, with out_ready randomized.
